// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state type, encodings and width helper for the FWFT FIFO reader
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'd2;

    function automatic int pos_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdc_skid_buf.sv
// cdc_skid_buf: 2-entry head+skid register buffer carrying data and a last flag.
// A pop shifts skid into head; a write lands in the first free slot after that shift.
module cdc_skid_buf
    import cdc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         wr_last,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_last,
    output occ_t         occ,
    output occ_t         occ_nxt
);

    logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
    logic         l0_q, l0_d, l1_q, l1_d;
    occ_t         occ_q, occ_p;

    always_comb begin
        occ_p = occ_q - occ_t'(pop);
        d0_d  = pop ? d1_q : d0_q;
        l0_d  = pop ? l1_q : l0_q;
        d1_d  = d1_q;
        l1_d  = l1_q;
        if (wr && occ_p == OCC_EMPTY) begin
            d0_d = wr_data;
            l0_d = wr_last;
        end
        if (wr && occ_p == 2'd1) begin
            d1_d = wr_data;
            l1_d = wr_last;
        end
        occ_nxt = clr ? OCC_EMPTY : occ_p + occ_t'(wr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_q  <= '0;
            d1_q  <= '0;
            l0_q  <= 1'b0;
            l1_q  <= 1'b0;
            occ_q <= OCC_EMPTY;
        end else begin
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            l0_q  <= l0_d;
            l1_q  <= l1_d;
            occ_q <= occ_nxt;
        end
    end

    assign head_data = d0_q;
    assign head_last = l0_q;
    assign occ       = occ_q;

endmodule

// File: rtl/cdc_fifo_reader.sv
// cdc_fifo_reader: drains an FWFT FIFO read port into a registered valid/ready stream
// with burst framing, a saturating beat counter and a discard-everything flush mode.
module cdc_fifo_reader
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    input  logic                  flush,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    localparam int            PW       = pos_width(BURST_LEN);
    localparam logic [PW-1:0] POS_LAST = PW'(BURST_LEN - 1);

    state_t               state_q, state_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    occ_t                 occ, occ_nxt;
    logic                 pop, clr, wr, head_last;

    // Entering or sitting in FLUSH clears the buffer; reads during FLUSH are dropped.
    assign busy       = state_q == FLUSH;
    assign clr        = flush || busy;
    assign fifo_rd_en = !rst && !fifo_empty && (busy || occ < OCC_FULL);
    assign wr         = fifo_rd_en && !clr;
    assign m_valid    = occ != OCC_EMPTY && !busy;
    assign m_last     = m_valid && head_last;
    assign pop        = m_valid && m_ready;
    assign beat_cnt   = cnt_q;

    cdc_skid_buf #(.W(DATA_WIDTH)) u_buf (
        .clk       (rd_clk),
        .rst       (rst),
        .clr       (clr),
        .wr        (wr),
        .wr_data   (fifo_dout),
        .wr_last   (pos_q == POS_LAST),
        .pop       (pop),
        .head_data (m_data),
        .head_last (head_last),
        .occ       (occ),
        .occ_nxt   (occ_nxt)
    );

    always_comb begin
        state_d = busy ? ((!flush && fifo_empty) ? IDLE : FLUSH)
                : flush ? FLUSH
                : (occ_nxt == OCC_EMPTY) ? IDLE : STREAM;
        pos_d   = clr ? '0 : !wr ? pos_q : (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        cnt_d   = (pop && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_reader.sv
// tb_cdc_fifo_reader: FWFT FIFO model plus a scoreboard of {last, data} beats,
// a vector table for the basic stream and hand-written sequences for the corner cases.
module tb_cdc_fifo_reader;

    localparam int DW = 16;
    localparam int BL = 4;
    localparam int CW = 4;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          flush = 1'b0;
    logic          busy;
    logic [CW-1:0] beat_cnt;

    always #5 rd_clk = ~rd_clk;

    cdc_fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .flush      (flush),
        .busy       (busy),
        .beat_cnt   (beat_cnt)
    );

    typedef struct {
        logic [DW-1:0] din;
        logic          last;
    } vec_t;

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    int passed = 0;
    int total  = 0;
    int wpos   = 0;
    int n_rd   = 0;
    int n_pop  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic refresh();
        fifo_empty = fifo_q.size() == 0;
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] w, input logic last);
        fifo_q.push_back(w);
        exp_q.push_back({last, w});
        refresh();
    endtask

    // Expected burst position is tracked from the words the bench itself enqueues.
    task automatic push_auto(input logic [DW-1:0] w);
        push(w, wpos == BL - 1);
        wpos = (wpos == BL - 1) ? 0 : wpos + 1;
    endtask

    // Sample on the falling edge, let the rising edge happen, then update the FIFO model.
    task automatic step();
        logic [DW:0] e;
        logic        rd;
        @(negedge rd_clk);
        rd = fifo_rd_en;
        n_rd += int'(rd);
        if (m_valid && m_ready) begin
            n_pop++;
            if (exp_q.size() == 0) chk("beat_avail", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("beat_data", m_data, e[DW-1:0]);
                chk("beat_last", m_last, e[DW]);
            end
        end
        @(posedge rd_clk);
        #1;
        if (rd && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            refresh();
        end
    endtask

    task automatic drain(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !m_valid) break;
            step();
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic clear_models();
        fifo_q.delete();
        exp_q.delete();
        wpos = 0;
        refresh();
    endtask

    initial begin
        vec_t tbl[8];
        tbl = '{'{16'h0001, 1'b0}, '{16'h0002, 1'b0}, '{16'h0003, 1'b0}, '{16'h0004, 1'b1},
                '{16'h0005, 1'b0}, '{16'h0006, 1'b0}, '{16'h0007, 1'b0}, '{16'h0008, 1'b1}};

        #2;
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", beat_cnt, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        @(posedge rd_clk);
        #1 rst = 1'b0;

        // Basic stream from the vector table
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(tbl[i].din, tbl[i].last);
        #1;
        chk("first_rd_en", fifo_rd_en, 1);
        chk("first_not_valid", m_valid, 0);
        n_pop = 0;
        step();
        chk("first_valid", m_valid, 1);
        chk("first_data", m_data, 16'h0001);
        repeat (8) step();
        chk("stream_pops", n_pop, 8);
        chk("stream_left", exp_q.size(), 0);
        chk("stream_cnt", beat_cnt, 8);
        wpos = 0;

        // Backpressure: only two words may be pulled while m_ready is low
        m_ready = 1'b0;
        push_auto(16'h0A01);
        push_auto(16'h0A02);
        push_auto(16'h0A03);
        n_rd = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, 16'h0A01);
        end
        chk("bp_rd_count", n_rd, 2);
        chk("bp_rd_en_low", fifo_rd_en, 0);
        m_ready = 1'b1;
        drain("bp_drain", 10);
        chk("bp_cnt", beat_cnt, 11);

        rst = 1'b1;
        clear_models();
        #2 rst = 1'b0;
        chk("rst2_cnt", beat_cnt, 0);

        // Toggling ready over 12 words
        for (int i = 0; i < 12; i++) push_auto(16'hB000 + 16'(i));
        n_pop = 0;
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !m_valid) break;
            m_ready = ~m_ready;
            step();
        end
        chk("toggle_pops", n_pop, 12);
        chk("toggle_left", exp_q.size(), 0);
        chk("toggle_cnt", beat_cnt, 12);

        // Flush with a full buffer and five words still in the FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) push_auto(16'hC000 + 16'(i));
        repeat (2) step();
        chk("pre_flush_fifo", fifo_q.size(), 5);
        exp_q.delete();
        wpos = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", busy, 1);
        n_rd = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            chk("flush_no_valid", m_valid, 0);
            step();
        end
        chk("flush_rd_count", n_rd, 5);
        chk("flush_busy_fall", busy, 0);
        chk("flush_keeps_cnt", beat_cnt, 12);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_auto(16'hD000 + 16'(i));
        drain("post_flush_drain", 20);
        chk("cnt_saturate_a", beat_cnt, 15);

        // Asynchronous reset with the buffer full
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_auto(16'hE000 + 16'(i));
        repeat (3) step();
        chk("pre_rst_valid", m_valid, 1);
        @(negedge rd_clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_last", m_last, 0);
        chk("arst_cnt", beat_cnt, 0);
        chk("arst_rd_en", fifo_rd_en, 0);
        @(posedge rd_clk);
        #1;
        chk("arst_rd_en_held", fifo_rd_en, 0);
        clear_models();
        rst = 1'b0;
        step();
        chk("post_rst_valid", m_valid, 0);

        // 20 beats into a 4-bit counter
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_auto(16'hF000 + 16'(i));
        drain("sat_drain", 40);
        chk("cnt_saturate_b", beat_cnt, 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
